// File: rtl/rv32i_mem_arbiter_if.sv
// Bundle of fetch, data and memory-side signals around the shared-memory arbiter.
// The slave view is the arbiter; the master view is the core plus RAM that surround it.
interface rv32i_mem_arbiter_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  i_req;
   logic [DATA_WIDTH-1:0] i_addr;
   logic                  i_gnt;
   logic                  i_valid;
   logic [DATA_WIDTH-1:0] i_rdata;

   logic                  d_req;
   logic [DATA_WIDTH-1:0] d_addr;
   logic [DATA_WIDTH-1:0] d_wdata;
   logic [3:0]            d_we;
   logic                  d_gnt;
   logic                  d_valid;
   logic [DATA_WIDTH-1:0] d_rdata;

   logic                  m_en;
   logic [DATA_WIDTH-1:0] m_addr;
   logic [DATA_WIDTH-1:0] m_wdata;
   logic [3:0]            m_we;
   logic [DATA_WIDTH-1:0] m_rdata;

   modport slave (
      input  i_req, i_addr,
      output i_gnt, i_valid, i_rdata,
      input  d_req, d_addr, d_wdata, d_we,
      output d_gnt, d_valid, d_rdata,
      output m_en, m_addr, m_wdata, m_we,
      input  m_rdata
   );

   modport master (
      output i_req, i_addr,
      input  i_gnt, i_valid, i_rdata,
      output d_req, d_addr, d_wdata, d_we,
      input  d_gnt, d_valid, d_rdata,
      input  m_en, m_addr, m_wdata, m_we,
      output m_rdata
   );
endinterface

// File: rtl/rv32i_mem_arbiter.sv
// Fetch/data arbiter for one fixed-latency single-port RAM with a tag pipe that steers read data back.
// Define ARB_STARVE_GUARD_EN to let a long-denied fetch override data priority.
module rv32i_mem_arbiter #(
   parameter int DATA_WIDTH   = 32,
   parameter int MEM_LAT      = 1,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                clk,
   input  logic                rst,
   rv32i_mem_arbiter_if.slave  bus
);
   localparam int DEPTH = MEM_LAT + 1;

   logic                  fetch_force;
   logic                  i_gnt_c;
   logic                  d_gnt_c;
   logic                  rd_grant;
   logic                  gnt_is_d;

   logic                  m_en_q;
   logic [DATA_WIDTH-1:0] m_addr_q;
   logic [DATA_WIDTH-1:0] m_wdata_q;
   logic [3:0]            m_we_q;

   logic [DEPTH-1:0]      tag_vld;
   logic [DEPTH-1:0]      tag_own_d;
   logic                  rsp_i;
   logic                  rsp_d;
   logic [DATA_WIDTH-1:0] i_rdata_q;
   logic [DATA_WIDTH-1:0] d_rdata_q;

`ifdef ARB_STARVE_GUARD_EN
   logic [3:0] starve_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         starve_cnt <= '0;
      end else if (!bus.i_req || i_gnt_c) begin
         starve_cnt <= '0;
      end else if (starve_cnt != 4'hf) begin
         starve_cnt <= starve_cnt + 4'd1;
      end
   end

   assign fetch_force = bus.i_req && (starve_cnt >= 4'(STARVE_LIMIT));
`else
   assign fetch_force = 1'b0;
`endif

   // Data normally wins; a forced fetch takes the slot from data.
   always_comb begin
      i_gnt_c = 1'b0;
      d_gnt_c = 1'b0;
      if (!rst) begin
         if (bus.d_req && !fetch_force) begin
            d_gnt_c = 1'b1;
         end else if (bus.i_req) begin
            i_gnt_c = 1'b1;
         end
      end
   end

   assign gnt_is_d = d_gnt_c;
   assign rd_grant = i_gnt_c || (d_gnt_c && (bus.d_we == 4'b0000));

   always_ff @(posedge clk) begin
      if (rst) begin
         m_en_q    <= 1'b0;
         m_addr_q  <= '0;
         m_wdata_q <= '0;
         m_we_q    <= 4'b0000;
      end else if (i_gnt_c) begin
         m_en_q    <= 1'b1;
         m_addr_q  <= bus.i_addr;
         m_wdata_q <= '0;
         m_we_q    <= 4'b0000;
      end else if (d_gnt_c) begin
         m_en_q    <= 1'b1;
         m_addr_q  <= bus.d_addr;
         m_wdata_q <= bus.d_wdata;
         m_we_q    <= bus.d_we;
      end else begin
         m_en_q    <= 1'b0;
         m_we_q    <= 4'b0000;
      end
   end

   // One stage per cycle of grant-to-data latency; stores enter as empty slots.
   always_ff @(posedge clk) begin
      if (rst) begin
         tag_vld   <= '0;
         tag_own_d <= '0;
      end else begin
         tag_vld   <= {tag_vld[DEPTH-2:0], rd_grant};
         tag_own_d <= {tag_own_d[DEPTH-2:0], gnt_is_d};
      end
   end

   assign rsp_i = !rst && tag_vld[DEPTH-1] && !tag_own_d[DEPTH-1];
   assign rsp_d = !rst && tag_vld[DEPTH-1] &&  tag_own_d[DEPTH-1];

   always_ff @(posedge clk) begin
      if (rst) begin
         i_rdata_q <= '0;
         d_rdata_q <= '0;
      end else begin
         if (rsp_i) begin
            i_rdata_q <= bus.m_rdata;
         end
         if (rsp_d) begin
            d_rdata_q <= bus.m_rdata;
         end
      end
   end

   // Read data is presented in the cycle it arrives and held afterwards.
   assign bus.i_gnt   = i_gnt_c;
   assign bus.d_gnt   = d_gnt_c;
   assign bus.i_valid = rsp_i;
   assign bus.d_valid = rsp_d;
   assign bus.i_rdata = rsp_i ? bus.m_rdata : i_rdata_q;
   assign bus.d_rdata = rsp_d ? bus.m_rdata : d_rdata_q;
   assign bus.m_en    = m_en_q;
   assign bus.m_addr  = m_addr_q;
   assign bus.m_wdata = m_wdata_q;
   assign bus.m_we    = m_we_q;
endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// Directed bench for rv32i_mem_arbiter with a one-cycle-latency RAM model.
// Build with ARB_STARVE_GUARD_EN defined to exercise the fetch starvation override.
module tb_rv32i_mem_arbiter;
   logic clk = 1'b0;
   logic rst;
   int   n_chk  = 0;
   int   n_fail = 0;
   int   first_i;
   logic dg_at;

   logic [31:0] mem [0:255];

   rv32i_mem_arbiter_if #(.DATA_WIDTH(32)) bus ();

   rv32i_mem_arbiter #(
      .DATA_WIDTH(32),
      .MEM_LAT(1),
      .STARVE_LIMIT(4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   // RAM: registered read of the old word, byte-lane writes on the same edge.
   always @(posedge clk) begin
      if (bus.m_en) begin
         bus.m_rdata <= mem[bus.m_addr[9:2]];
         for (int b = 0; b < 4; b++) begin
            if (bus.m_we[b]) mem[bus.m_addr[9:2]][8*b +: 8] <= bus.m_wdata[8*b +: 8];
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'h1111_0000 + 32'(i);
      bus.m_rdata = '0;
      rst         = 1'b1;
      bus.i_req   = 1'b1;
      bus.i_addr  = 32'h0;
      bus.d_req   = 1'b0;
      bus.d_addr  = 32'h0;
      bus.d_wdata = 32'h0;
      bus.d_we    = 4'b0000;

      cyc();
      @(negedge clk);
      chk("rst_i_gnt",   32'(bus.i_gnt),   32'h0);
      chk("rst_d_gnt",   32'(bus.d_gnt),   32'h0);
      chk("rst_m_en",    32'(bus.m_en),    32'h0);
      chk("rst_m_we",    32'(bus.m_we),    32'h0);
      chk("rst_m_addr",  bus.m_addr,       32'h0);
      chk("rst_i_valid", 32'(bus.i_valid), 32'h0);
      chk("rst_d_valid", 32'(bus.d_valid), 32'h0);
      chk("rst_i_rdata", bus.i_rdata,      32'h0);
      chk("rst_d_rdata", bus.d_rdata,      32'h0);
      cyc();
      rst = 1'b0;

      // fetch stream 0,4,8
      @(negedge clk);
      chk("fs0_i_gnt", 32'(bus.i_gnt), 32'h1);
      chk("fs0_d_gnt", 32'(bus.d_gnt), 32'h0);
      cyc(); bus.i_addr = 32'h4;
      @(negedge clk);
      chk("fs1_m_en",    32'(bus.m_en), 32'h1);
      chk("fs1_m_addr",  bus.m_addr,    32'h0);
      chk("fs1_m_we",    32'(bus.m_we), 32'h0);
      chk("fs1_m_wdata", bus.m_wdata,   32'h0);
      chk("fs1_i_gnt",   32'(bus.i_gnt), 32'h1);
      chk("fs1_i_valid", 32'(bus.i_valid), 32'h0);
      cyc(); bus.i_addr = 32'h8;
      @(negedge clk);
      chk("fs2_i_valid", 32'(bus.i_valid), 32'h1);
      chk("fs2_i_rdata", bus.i_rdata,      32'h1111_0000);
      chk("fs2_m_addr",  bus.m_addr,       32'h4);
      cyc(); bus.i_req = 1'b0;
      @(negedge clk);
      chk("fs3_i_valid", 32'(bus.i_valid), 32'h1);
      chk("fs3_i_rdata", bus.i_rdata,      32'h1111_0001);
      chk("fs3_m_addr",  bus.m_addr,       32'h8);
      chk("fs3_i_gnt",   32'(bus.i_gnt),   32'h0);
      cyc();
      @(negedge clk);
      chk("fs4_i_valid", 32'(bus.i_valid), 32'h1);
      chk("fs4_i_rdata", bus.i_rdata,      32'h1111_0002);
      chk("fs4_m_en",    32'(bus.m_en),    32'h0);
      cyc();
      @(negedge clk);
      chk("fs5_i_valid", 32'(bus.i_valid), 32'h0);
      chk("fs5_i_hold",  bus.i_rdata,      32'h1111_0002);

      // contention: data load at 0x100 against fetch at 0xC
      cyc();
      bus.i_req = 1'b1; bus.i_addr = 32'hC;
      bus.d_req = 1'b1; bus.d_addr = 32'h100; bus.d_we = 4'b0000;
      @(negedge clk);
      chk("ct0_d_gnt", 32'(bus.d_gnt), 32'h1);
      chk("ct0_i_gnt", 32'(bus.i_gnt), 32'h0);
      cyc(); bus.d_req = 1'b0;
      @(negedge clk);
      chk("ct1_i_gnt",  32'(bus.i_gnt), 32'h1);
      chk("ct1_m_en",   32'(bus.m_en),  32'h1);
      chk("ct1_m_addr", bus.m_addr,     32'h100);
      cyc(); bus.i_req = 1'b0;
      @(negedge clk);
      chk("ct2_d_valid", 32'(bus.d_valid), 32'h1);
      chk("ct2_d_rdata", bus.d_rdata,      32'h1111_0040);
      chk("ct2_i_valid", 32'(bus.i_valid), 32'h0);
      chk("ct2_m_addr",  bus.m_addr,       32'hC);
      cyc();
      @(negedge clk);
      chk("ct3_i_valid", 32'(bus.i_valid), 32'h1);
      chk("ct3_i_rdata", bus.i_rdata,      32'h1111_0003);
      chk("ct3_d_valid", 32'(bus.d_valid), 32'h0);

      // partial store to 0x40 then readback
      cyc();
      bus.d_req = 1'b1; bus.d_addr = 32'h40; bus.d_we = 4'b1100; bus.d_wdata = 32'hAABB_0000;
      @(negedge clk);
      chk("st0_d_gnt", 32'(bus.d_gnt), 32'h1);
      cyc(); bus.d_req = 1'b0; bus.d_we = 4'b0000; bus.d_wdata = 32'h0;
      @(negedge clk);
      chk("st1_m_en",    32'(bus.m_en),    32'h1);
      chk("st1_m_we",    32'(bus.m_we),    32'hC);
      chk("st1_m_wdata", bus.m_wdata,      32'hAABB_0000);
      chk("st1_m_addr",  bus.m_addr,       32'h40);
      chk("st1_d_valid", 32'(bus.d_valid), 32'h0);
      cyc();
      @(negedge clk);
      chk("st2_d_valid", 32'(bus.d_valid), 32'h0);
      chk("st2_m_we",    32'(bus.m_we),    32'h0);
      cyc(); bus.d_req = 1'b1;
      @(negedge clk);
      chk("st3_d_gnt",   32'(bus.d_gnt),   32'h1);
      chk("st3_d_valid", 32'(bus.d_valid), 32'h0);
      cyc(); bus.d_req = 1'b0;
      @(negedge clk);
      chk("st4_d_valid", 32'(bus.d_valid), 32'h0);
      chk("st4_m_we",    32'(bus.m_we),    32'h0);
      cyc();
      @(negedge clk);
      chk("st5_d_valid", 32'(bus.d_valid), 32'h1);
      chk("st5_d_rdata", bus.d_rdata,      32'hAABB_0010);

      // starvation: both requests held
      cyc();
      bus.d_req = 1'b1; bus.d_addr = 32'h80; bus.d_we = 4'b0000;
      bus.i_req = 1'b1; bus.i_addr = 32'h20;
      first_i = 0;
      dg_at   = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (bus.i_gnt && first_i == 0) begin
            first_i = k;
            dg_at   = bus.d_gnt;
         end
         cyc();
         if (first_i != 0) begin
            bus.i_req = 1'b0;
            break;
         end
      end
      bus.i_req = 1'b0;
`ifdef ARB_STARVE_GUARD_EN
      chk("sv_first_i_gnt", 32'(first_i), 32'd5);
      chk("sv_d_gnt_force", 32'(dg_at),   32'h0);
`else
      chk("sv_first_i_gnt", 32'(first_i), 32'd0);
`endif
      @(negedge clk);
      chk("sv_d_resume", 32'(bus.d_gnt), 32'h1);
      cyc(); bus.d_req = 1'b0;
      cyc(); cyc(); cyc(); cyc();

      // reset while a data read and a fetch are in flight
      bus.i_req = 1'b1; bus.i_addr = 32'h10;
      bus.d_req = 1'b1; bus.d_addr = 32'h104;
      @(negedge clk);
      chk("mf0_d_gnt", 32'(bus.d_gnt), 32'h1);
      cyc(); bus.d_req = 1'b0;
      @(negedge clk);
      chk("mf1_i_gnt", 32'(bus.i_gnt), 32'h1);
      cyc(); bus.i_req = 1'b0; rst = 1'b1;
      @(negedge clk);
      chk("mf2_d_valid", 32'(bus.d_valid), 32'h0);
      chk("mf2_i_valid", 32'(bus.i_valid), 32'h0);
      cyc(); rst = 1'b0;
      @(negedge clk);
      chk("mf3_m_en",    32'(bus.m_en),    32'h0);
      chk("mf3_i_valid", 32'(bus.i_valid), 32'h0);
      chk("mf3_d_valid", 32'(bus.d_valid), 32'h0);
      chk("mf3_i_rdata", bus.i_rdata,      32'h0);
      chk("mf3_d_rdata", bus.d_rdata,      32'h0);
      cyc();
      @(negedge clk);
      chk("mf4_i_valid", 32'(bus.i_valid), 32'h0);
      chk("mf4_d_valid", 32'(bus.d_valid), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
